// File: rtl/cpu_pkg.sv
// Shared types for the fetch/decode controller: FSM states, bus source codes,
// width defaults and the per-state strobe pattern.
package cpu_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T0     = 3'd1,
    S_T1     = 3'd2,
    S_T2     = 3'd3,
    S_T3     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  typedef struct packed {
    logic       mem_read;
    logic       exec_req;
    logic       busy;
    logic [2:0] bus_sel;
    logic [3:0] t_oh;
  } strobe_t;

  // Strobes that hold for the whole time the FSM sits in state s.
  function automatic strobe_t strobes_for(state_t s);
    strobe_t o;
    o = '0;
    case (s)
      S_T0: begin
        o.busy    = 1'b1;
        o.bus_sel = BUS_PC;
        o.t_oh    = 4'b0001;
      end
      S_T1: begin
        o.busy     = 1'b1;
        o.mem_read = 1'b1;
        o.bus_sel  = BUS_MEM;
        o.t_oh     = 4'b0010;
      end
      S_T2: begin
        o.busy    = 1'b1;
        o.bus_sel = BUS_IR;
        o.t_oh    = 4'b0100;
      end
      S_T3: begin
        o.busy     = 1'b1;
        o.exec_req = 1'b1;
        o.bus_sel  = BUS_AR;
        o.t_oh     = 4'b1000;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/op_decoder.sv
// Combinational 3-to-8 one-hot decode of the instruction opcode field.
module op_decoder (
  input  logic [2:0] op_i,
  output logic [7:0] oh_o
);

  assign oh_o = 8'b0000_0001 << op_i;

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer: IDLE -> T0 (AR<=PC) -> T1 (memory read) -> T2 (decode)
// -> T3 (execute handshake) -> T0, with HALTED taken at an instruction boundary.
module fetch_decode_ctrl
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  input  logic [AW-1:0] pc_val,
  input  logic          exec_done,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic          pc_incr,
  output logic [2:0]    bus_sel,
  output logic [DW-1:0] ir_out,
  output logic          i_bit,
  output logic [7:0]    opcode_oh,
  output logic          exec_req,
  output logic [3:0]    t_oh,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  state_t        state_q, state_d;
  strobe_t       strb_q;
  logic [AW-1:0] ar_q;
  logic [DW-1:0] ir_q;
  logic          i_bit_q;
  logic [7:0]    opcode_q;
  logic [7:0]    dec_oh;
  logic          pc_incr_q;

  op_decoder u_op_decoder (
    .op_i (ir_q[DW-2 -: 3]),
    .oh_o (dec_oh)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_T0;
      S_T0:     state_d = S_T1;
      S_T1:     if (mem_ready) state_d = S_T2;
      S_T2:     state_d = S_T3;
      S_T3:     if (exec_done) state_d = halt ? S_HALTED : S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they never glitch; pc_incr
  // therefore pulses in the single T2 cycle that follows the IR capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      strb_q    <= '0;
      ar_q      <= '0;
      ir_q      <= '0;
      i_bit_q   <= 1'b0;
      opcode_q  <= '0;
      pc_incr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strobes_for(state_d);
      pc_incr_q <= (state_q == S_T1) && mem_ready;
      if (state_q == S_T0) ar_q <= pc_val;
      if ((state_q == S_T1) && mem_ready) ir_q <= mem_rdata;
      if (state_q == S_T2) begin
        ar_q     <= ir_q[AW-1:0];
        i_bit_q  <= ir_q[DW-1];
        opcode_q <= dec_oh;
      end
    end
  end

  assign mem_read  = strb_q.mem_read;
  assign exec_req  = strb_q.exec_req;
  assign busy      = strb_q.busy;
  assign bus_sel   = strb_q.bus_sel;
  assign t_oh      = strb_q.t_oh;
  assign mem_addr  = ar_q;
  assign pc_incr   = pc_incr_q;
  assign ir_out    = ir_q;
  assign i_bit     = i_bit_q;
  assign opcode_oh = opcode_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench for fetch_decode_ctrl: vector table plus random
// instructions through a scoreboard, then halt and reset corner sequences.
module tb_fetch_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, mem_ready, exec_done;
  logic [15:0] mem_rdata;
  logic [11:0] pc_val;
  logic        mem_read, pc_incr, i_bit, exec_req, busy;
  logic [11:0] mem_addr;
  logic [2:0]  bus_sel, dbg_state;
  logic [15:0] ir_out;
  logic [7:0]  opcode_oh;
  logic [3:0]  t_oh;

  int total = 0;
  int bad   = 0;

  // {i_bit, opcode_oh, mem_addr, ir}
  logic [36:0] exp_q[$];

  typedef struct {
    logic [15:0] rdata;
    logic [11:0] pc;
    int          rwait;
    int          ewait;
    logic        exp_i;
    logic [7:0]  exp_oh;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  fetch_decode_ctrl #(.AW(12), .DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt      (halt),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_val    (pc_val),
    .exec_done (exec_done),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .pc_incr   (pc_incr),
    .bus_sel   (bus_sel),
    .ir_out    (ir_out),
    .i_bit     (i_bit),
    .opcode_oh (opcode_oh),
    .exec_req  (exec_req),
    .t_oh      (t_oh),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {mem_read, mem_addr, pc_incr, bus_sel, ir_out, i_bit,
               opcode_oh, exec_req, t_oh, busy}, 64'd0);
  endtask

  // Entered with the DUT observed in T0; leaves it in T0 or HALTED.
  task automatic do_instr(input vec_t v, input bit halt_t1);
    logic [15:0] ir_before;
    logic [36:0] e;
    int cyc, nrd, nex;
    chk("t0_state", t_oh, 4'b0001);
    chk("t0_bus", bus_sel, 3'd2);
    chk("t0_busy", busy, 1'b1);
    ir_before = ir_out;
    exp_q.push_back({v.exp_i, v.exp_oh, v.exp_addr, v.rdata});
    pc_val = v.pc; mem_rdata = v.rdata;
    mem_ready = 1'b1; exec_done = 1'b1;   // both must be ignored in T0
    step(); cyc = 1;
    chk("t1_state", t_oh, 4'b0010);
    chk("t1_addr", mem_addr, v.pc);
    chk("t1_bus", bus_sel, 3'd7);
    if (halt_t1) halt = 1'b1;
    exec_done = 1'b0;
    nrd = 0;
    for (int i = 0; i < v.rwait; i++) begin
      if (mem_read) nrd++;
      mem_ready = 1'b0;
      step(); cyc++;
      chk("stall_state", t_oh, 4'b0010);
      chk("stall_pc_incr", pc_incr, 1'b0);
      chk("stall_ir", ir_out, ir_before);
    end
    if (mem_read) nrd++;
    mem_ready = 1'b1;
    step(); cyc++;
    chk("rd_cycles", nrd, v.rwait + 1);
    chk("t2_state", t_oh, 4'b0100);
    chk("t2_pc_incr", pc_incr, 1'b1);
    chk("t2_bus", bus_sel, 3'd5);
    chk("t2_mem_read", mem_read, 1'b0);
    step(); cyc++;
    chk("t3_state", t_oh, 4'b1000);
    chk("t3_pc_incr", pc_incr, 1'b0);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_ir", ir_out, e[15:0]);
      chk("sb_addr", mem_addr, e[27:16]);
      chk("sb_opcode", opcode_oh, e[35:28]);
      chk("sb_i_bit", i_bit, e[36]);
    end
    nex = 0;
    for (int i = 0; i < v.ewait; i++) begin
      if (exec_req) nex++;
      exec_done = 1'b0;
      step(); cyc++;
      chk("t3_wait_state", t_oh, 4'b1000);
    end
    if (exec_req) nex++;
    exec_done = 1'b1;
    step(); cyc++;
    exec_done = 1'b0;
    chk("ex_cycles", nex, v.ewait + 1);
    chk("instr_cycles", cyc, 4 + v.rwait + v.ewait);
    if (halt_t1) begin
      chk("halted_t_oh", t_oh, 4'b0000);
      chk("halted_busy", busy, 1'b0);
      chk("halted_strobes", {mem_read, exec_req, pc_incr}, 3'b000);
    end else begin
      chk("back_t0", t_oh, 4'b0001);
      chk("back_t0_addr", mem_addr, v.exp_addr);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;
    vecs[0] = '{16'h9ABC, 12'h005, 0, 0, 1'b1, 8'h02, 12'hABC};
    vecs[1] = '{16'h7001, 12'h010, 3, 0, 1'b0, 8'h80, 12'h001};
    vecs[2] = '{16'h0FFF, 12'hFFF, 0, 5, 1'b0, 8'h01, 12'hFFF};
    vecs[3] = '{16'hF000, 12'h123, 1, 2, 1'b1, 8'h80, 12'h000};
    vecs[4] = '{16'hB5A5, 12'h7FE, 2, 1, 1'b1, 8'h08, 12'h5A5};
    vecs[5] = '{16'h4321, 12'h000, 0, 3, 1'b0, 8'h10, 12'h321};

    rst_n = 1'b0; start = 1'b0; halt = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
    mem_rdata = '0; pc_val = '0;
    #3;
    chk_reset_vals("reset_async");
    step(); step();
    rst_n = 1'b1;
    step();
    chk_reset_vals("reset_release");
    step();
    chk("idle_hold", {busy, t_oh}, 5'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) do_instr(vecs[i], 1'b0);

    for (int i = 0; i < 6; i++) begin
      rv.rdata    = 16'($urandom_range(0, 16'hFFFF));
      rv.pc       = 12'($urandom_range(0, 12'hFFF));
      rv.rwait    = $urandom_range(0, 3);
      rv.ewait    = $urandom_range(0, 3);
      rv.exp_i    = rv.rdata[15];
      rv.exp_oh   = 8'd1 << rv.rdata[14:12];
      rv.exp_addr = rv.rdata[11:0];
      do_instr(rv, 1'b0);
    end

    // halt raised in T1: the instruction completes, then HALTED ignores start
    do_instr(vecs[1], 1'b1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halted_start_ignored", {busy, t_oh, mem_read}, 6'd0);
    end
    start = 1'b0; halt = 1'b0;

    // reset during a T1 stall
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    start = 1'b1; mem_ready = 1'b0; pc_val = 12'h055;
    step();
    start = 1'b0;
    chk("rst2_t0", t_oh, 4'b0001);
    step(); step(); step();
    chk("rst2_stalled", t_oh, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_mid_t1");
    mem_ready = 1'b1; exec_done = 1'b1;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_reset_quiet", {pc_incr, exec_req, busy, mem_read}, 4'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_ctrl.md
FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

Interface
REQ-001 Parameter AW, default 12, memory address width.
REQ-002 Parameter DW, default 16, instruction/data word width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; begins fetching from IDLE.
REQ-006 halt  input  1  level; stops the machine at the next instruction boundary.
REQ-007 mem_rdata  input  DW  instruction word returned by memory.
REQ-008 mem_ready  input  1  memory read data valid this cycle.
REQ-009 pc_val  input  AW  current program counter value.
REQ-010 exec_done  input  1  execute stage finished the current instruction.
REQ-011 mem_read  output  1  memory read strobe.
REQ-012 mem_addr  output  AW  memory address, equal to the AR contents.
REQ-013 pc_incr  output  1  single-cycle PC increment pulse.
REQ-014 bus_sel  output  3  bus source code: 0 none, 1 AR, 2 PC, 5 IR, 7 MEM.
REQ-015 ir_out  output  DW  instruction register.
REQ-016 i_bit  output  1  indirect bit, IR[15] latched at decode.
REQ-017 opcode_oh  output  8  one-hot decode of IR[14:12].
REQ-018 exec_req  output  1  request to execute stage.
REQ-019 t_oh  output  4  one-hot timing state T0..T3; all zero in IDLE/HALTED.
REQ-020 busy  output  1  high in any state except IDLE and HALTED.

Function
REQ-021 States: IDLE, T0, T1, T2, T3, HALTED; exactly one is active.
REQ-022 IDLE: start=1 moves to T0 on the next edge; otherwise remain in IDLE.
REQ-023 T0: bus_sel=2; AR<=pc_val; move to T1 after one cycle.
REQ-024 T1: mem_read=1 and bus_sel=7 every cycle until mem_ready=1.
REQ-025 T1 with mem_ready=1: IR<=mem_rdata; pc_incr=1 for exactly that cycle; move to T2.
REQ-026 T1 with mem_ready=0: hold in T1, with no pc_incr and no IR change.
REQ-027 T2: bus_sel=5; AR<=IR[11:0]; i_bit<=IR[15]; opcode_oh<=1<<IR[14:12]; move to T3.
REQ-028 T3: exec_req=1 until the cycle in which exec_done=1.
REQ-029 T3 with exec_done=1 and halt=0: move to T0.
REQ-030 T3 with exec_done=1 and halt=1: move to HALTED.
REQ-031 Fetch latency with mem_ready tied high: 4 cycles per instruction, T0 through T3 with single-cycle exec_done.
REQ-032 halt asserted in any state other than T3 has no effect until T3 completes; the instruction in flight always finishes.
REQ-033 HALTED: all strobes low; leave only via reset; start is ignored.
REQ-034 exec_done outside T3 is ignored.
REQ-035 mem_ready outside T1 is ignored.
REQ-036 mem_addr always reflects AR; AR changes only in T0 and T2.
REQ-037 pc_incr, mem_read and exec_req are registered outputs; none may glitch.

Reset
REQ-038 rst_n low forces IDLE immediately, without waiting for a clock edge.
REQ-039 Reset values: AR=0, IR=0, i_bit=0, opcode_oh=0, all strobes 0, bus_sel=0, t_oh=0, busy=0.
REQ-040 Reset mid-fetch (T1 stalled) or mid-execute: no pc_incr or exec_req pulse is emitted after rst_n deasserts.

Structure
REQ-041 Shared package cpu_pkg holds the state enum, the bus_sel codes (NONE, AR, PC, IR, MEM) and the AW/DW defaults.
REQ-042 One sub-module, op_decoder, is combinational 3-to-8 one-hot decode of IR[14:12]; its output is registered in the parent.

Verification
REQ-043 Reset then start=1, pc_val=0x005, mem_rdata=0x9ABC, mem_ready=1, exec_done=1 in T3 -> ir_out=0x9ABC, i_bit=1, opcode_oh=0x02, mem_addr=0xABC, one pc_incr pulse, back in T0 on cycle 5.
REQ-044 T1 with mem_ready low for 3 cycles -> mem_read high for 4 cycles, single pc_incr on the 4th, IR unchanged before then.
REQ-045 T3 with exec_done delayed 5 cycles -> exec_req high for 6 cycles, then T0.
REQ-046 halt=1 asserted in T1 -> instruction completes, HALTED after T3; start=1 afterwards leaves busy=0.
REQ-047 rst_n pulled low during a T1 stall -> all outputs at reset values asynchronously; no pc_incr after release.
REQ-048 mem_rdata=0x7001 -> i_bit=0, opcode_oh=0x80, mem_addr=0x001.
